// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-port arbiter: owner encoding, FSM states and
// the round-robin pick between the instruction-cache and data-cache requesters.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int LINE_W_DEF = 256;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IC   = 2'b01,
    OWN_DC   = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY_IC,
    ST_BUSY_DC,
    ST_GAP
  } state_e;

  // On a tie the requester that did not own the port last time wins.
  function automatic owner_e pick_owner(logic ic_req, logic dc_req, owner_e last_owner);
    if (ic_req && dc_req) return (last_owner == OWN_DC) ? OWN_IC : OWN_DC;
    if (ic_req)           return OWN_IC;
    if (dc_req)           return OWN_DC;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single line-wide memory port between icache and dcache; one
// transaction at a time, round-robin on contention, ack/data routed to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ic_req_i,
  input  logic [ADDR_W-1:0] ic_addr_i,
  output logic [LINE_W-1:0] ic_data_o,
  output logic              ic_ack_o,
  input  logic              dc_req_i,
  input  logic              dc_write_i,
  input  logic [ADDR_W-1:0] dc_addr_i,
  input  logic [LINE_W-1:0] dc_data_i,
  output logic [LINE_W-1:0] dc_data_o,
  output logic              dc_ack_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [1:0]        owner_o
);

  state_e              state;
  owner_e              last_owner;
  owner_e              pick;
  logic [ADDR_W-1:0]   addr_q;
  logic [LINE_W-1:0]   data_q;
  logic                write_q;

  assign pick = pick_owner(ic_req_i, dc_req_i, last_owner);

  // NOTE: all state is updated with non-blocking assignments so every branch
  // sees the pre-edge values of state and last_owner.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= ST_IDLE;
      last_owner <= OWN_IC;
      addr_q     <= '0;
      data_q     <= '0;
      write_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          case (pick)
            OWN_IC: begin
              state      <= ST_BUSY_IC;
              last_owner <= OWN_IC;
              addr_q     <= ic_addr_i;
              data_q     <= '0;
              write_q    <= 1'b0;
            end
            OWN_DC: begin
              state      <= ST_BUSY_DC;
              last_owner <= OWN_DC;
              addr_q     <= dc_addr_i;
              data_q     <= dc_data_i;
              write_q    <= dc_write_i;
            end
            default: ;
          endcase
        end
        ST_BUSY_IC, ST_BUSY_DC: begin
          // Write flag drops together with enable so the GAP cycle is clean.
          if (mem_ack_i) begin
            state   <= ST_GAP;
            write_q <= 1'b0;
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_enable_o = (state == ST_BUSY_IC) || (state == ST_BUSY_DC);
  assign mem_write_o  = write_q;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;

  assign owner_o = (state == ST_BUSY_IC) ? OWN_IC :
                   (state == ST_BUSY_DC) ? OWN_DC : OWN_NONE;

  // Acks only reach the current owner; read data is a plain pass-through.
  assign ic_ack_o  = (state == ST_BUSY_IC) && mem_ack_i;
  assign dc_ack_o  = (state == ST_BUSY_DC) && mem_ack_i;
  assign ic_data_o = mem_data_i;
  assign dc_data_o = mem_data_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: requester tasks drive stimulus and queue the
// expected grants/acks; a monitor pops and compares whenever the DUT grants or acks.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW      = 32;
  localparam int LW      = 256;
  localparam int MEM_LAT = 10;
  localparam int TMO     = 200;

  typedef struct {
    logic [1:0]    owner;
    logic [AW-1:0] addr;
    logic          wr;
    logic [LW-1:0] wdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          ic_req, dc_req, dc_write;
  logic [AW-1:0] ic_addr, dc_addr;
  logic [LW-1:0] dc_wdata;
  logic [LW-1:0] ic_data_o, dc_data_o;
  logic          ic_ack_o, dc_ack_o;
  logic          mem_enable_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_data_o;
  logic [LW-1:0] mem_rdata;
  logic          model_ack, spur_ack, mem_ack;
  logic [1:0]    owner_o;

  int   vectors     = 0;
  int   miscompares = 0;
  txn_t grant_q[$];
  txn_t ack_q[$];

  assign mem_ack = model_ack | spur_ack;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .ic_req_i     (ic_req),
    .ic_addr_i    (ic_addr),
    .ic_data_o    (ic_data_o),
    .ic_ack_o     (ic_ack_o),
    .dc_req_i     (dc_req),
    .dc_write_i   (dc_write),
    .dc_addr_i    (dc_addr),
    .dc_data_i    (dc_wdata),
    .dc_data_o    (dc_data_o),
    .dc_ack_o     (dc_ack_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (mem_ack),
    .owner_o      (owner_o)
  );

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_txn(input logic [1:0] owner, input logic [AW-1:0] addr,
                            input logic wr, input logic [LW-1:0] wdata, input bit acked);
    txn_t t;
    t.owner = owner;
    t.addr  = addr;
    t.wr    = wr;
    t.wdata = wdata;
    grant_q.push_back(t);
    if (acked) ack_q.push_back(t);
  endtask

  // Memory model: ack exactly MEM_LAT cycles after enable rises, data = {8{addr}}.
  initial begin
    int cnt;
    cnt       = 0;
    model_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_i) begin
        cnt       = 0;
        model_ack = 1'b0;
      end else if (model_ack) begin
        model_ack = 1'b0;
        cnt       = 0;
      end else if (mem_enable_o) begin
        if (cnt == MEM_LAT) begin
          model_ack = 1'b1;
          mem_rdata = {8{mem_addr_o}};
          cnt       = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    txn_t cur, e;
    bit   in_busy;
    int   busy_len;
    in_busy  = 0;
    busy_len = 0;
    cur      = '{owner: 2'b00, addr: '0, wr: 1'b0, wdata: '0};
    forever begin
      @(negedge clk);
      if (!rst_i) begin
        in_busy = 0;
      end else begin
        if (mem_enable_o && !in_busy) begin
          if (grant_q.size() == 0) begin
            check("unexpected_grant", mem_enable_o, 1'b0);
            cur = '{owner: owner_o, addr: mem_addr_o, wr: mem_write_o, wdata: mem_data_o};
          end else begin
            cur = grant_q.pop_front();
          end
          in_busy  = 1;
          busy_len = 0;
        end
        if (in_busy && mem_enable_o) begin
          busy_len++;
          check("busy_owner", owner_o, cur.owner);
          check("busy_addr", mem_addr_o, cur.addr);
          check("busy_write", mem_write_o, cur.wr);
          check("busy_wdata", mem_data_o, cur.wdata);
        end
        if (ic_ack_o || dc_ack_o) begin
          check("single_ack", ic_ack_o & dc_ack_o, 1'b0);
          if (ack_q.size() == 0) begin
            check("unexpected_ack", ic_ack_o | dc_ack_o, 1'b0);
          end else begin
            e = ack_q.pop_front();
            check("ack_side", {dc_ack_o, ic_ack_o}, e.owner);
            check("ack_data", (e.owner == OWN_IC) ? ic_data_o : dc_data_o, {8{e.addr}});
            check("busy_len", busy_len, MEM_LAT + 1);
          end
        end
        if (in_busy && !mem_enable_o) begin
          in_busy = 0;
          check("gap_write", mem_write_o, 1'b0);
          check("gap_owner", owner_o, OWN_NONE);
        end
      end
    end
  end

  task automatic ic_run(input logic [AW-1:0] addr);
    bit got;
    got     = 0;
    ic_addr = addr;
    ic_req  = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (ic_ack_o) begin
        got = 1;
        break;
      end
    end
    check("ic_ack_seen", got, 1'b1);
    @(posedge clk);
    #2;
    ic_req = 1'b0;
  endtask

  task automatic dc_run(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] data,
                        input bit toggle, input int drop_after);
    bit got;
    int c;
    got      = 0;
    c        = 0;
    dc_write = wr;
    dc_addr  = addr;
    dc_wdata = data;
    dc_req   = 1'b1;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (owner_o == OWN_DC) begin
        got = 1;
        break;
      end
    end
    check("dc_grant_seen", got, 1'b1);
    got = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      c++;
      if (dc_ack_o) begin
        got = 1;
        break;
      end
      if (toggle) begin
        dc_wdata = ~dc_wdata;
        dc_addr  = dc_addr ^ 32'hFFFF_0000;
        dc_write = ~dc_write;
      end
      if (drop_after > 0 && c == drop_after) dc_req = 1'b0;
    end
    check("dc_ack_seen", got, 1'b1);
    @(posedge clk);
    #2;
    dc_req = 1'b0;
  endtask

  initial begin
    bit got;
    rst_i    = 1'b0;
    ic_req   = 1'b0;
    dc_req   = 1'b0;
    dc_write = 1'b0;
    ic_addr  = '0;
    dc_addr  = '0;
    dc_wdata = '0;
    spur_ack = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_i = 1'b1;

    @(negedge clk);
    check("rst_enable", mem_enable_o, 1'b0);
    check("rst_owner", owner_o, OWN_NONE);
    check("rst_write", mem_write_o, 1'b0);
    check("rst_addr", mem_addr_o, '0);
    check("rst_wdata", mem_data_o, '0);
    check("rst_acks", {ic_ack_o, dc_ack_o}, 2'b00);

    // Reset in the middle of a dcache transaction.
    @(posedge clk);
    #2;
    expect_txn(OWN_DC, 32'h0000_0300, 1'b0, '0, 0);
    dc_addr  = 32'h0000_0300;
    dc_write = 1'b0;
    dc_req   = 1'b1;
    got      = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (owner_o == OWN_DC) begin
        got = 1;
        break;
      end
    end
    check("t1_grant_seen", got, 1'b1);
    repeat (3) @(negedge clk);
    #2;
    rst_i  = 1'b0;
    dc_req = 1'b0;
    #1;
    check("t1_rst_enable", mem_enable_o, 1'b0);
    check("t1_rst_owner", owner_o, OWN_NONE);
    @(negedge clk);
    @(posedge clk);
    #2 rst_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("t1_idle_enable", mem_enable_o, 1'b0);
      check("t1_idle_owner", owner_o, OWN_NONE);
    end

    // Ties: dcache wins first after reset, then again once icache has had its turn.
    @(posedge clk);
    #2;
    expect_txn(OWN_DC, 32'h0000_1000, 1'b0, '0, 1);
    expect_txn(OWN_IC, 32'h0000_2000, 1'b0, '0, 1);
    expect_txn(OWN_DC, 32'h0000_1100, 1'b0, '0, 1);
    expect_txn(OWN_IC, 32'h0000_2100, 1'b0, '0, 1);
    fork
      ic_run(32'h0000_2000);
      dc_run(1'b0, 32'h0000_1000, '0, 0, 0);
    join
    fork
      ic_run(32'h0000_2100);
      dc_run(1'b0, 32'h0000_1100, '0, 0, 0);
    join

    // Lone icache fill.
    repeat (2) @(posedge clk);
    #2;
    expect_txn(OWN_IC, 32'h0000_0040, 1'b0, '0, 1);
    ic_run(32'h0000_0040);

    // Write-back with inputs toggling during BUSY.
    repeat (2) @(posedge clk);
    #2;
    expect_txn(OWN_DC, 32'h0000_0200, 1'b1, {32{8'hA5}}, 1);
    dc_run(1'b1, 32'h0000_0200, {32{8'hA5}}, 1, 0);

    // Request withdrawn three cycles into BUSY.
    repeat (2) @(posedge clk);
    #2;
    expect_txn(OWN_DC, 32'h0000_0400, 1'b0, '0, 1);
    dc_run(1'b0, 32'h0000_0400, '0, 0, 3);

    // Spurious mem ack while IDLE.
    repeat (3) @(posedge clk);
    #2 spur_ack = 1'b1;
    @(negedge clk);
    check("idle_spur_acks", {ic_ack_o, dc_ack_o}, 2'b00);
    @(posedge clk);
    #2 spur_ack = 1'b0;
    @(negedge clk);
    check("idle_spur_enable", mem_enable_o, 1'b0);
    check("idle_spur_owner", owner_o, OWN_NONE);

    // Spurious mem ack during GAP.
    @(posedge clk);
    #2;
    expect_txn(OWN_IC, 32'h0000_0080, 1'b0, '0, 1);
    fork
      ic_run(32'h0000_0080);
      begin
        got = 0;
        for (int i = 0; i < TMO; i++) begin
          @(negedge clk);
          if (ic_ack_o) begin
            got = 1;
            break;
          end
        end
        @(posedge clk);
        #2 spur_ack = 1'b1;
        @(negedge clk);
        check("gap_spur_acks", {ic_ack_o, dc_ack_o}, 2'b00);
        check("gap_spur_enable", mem_enable_o, 1'b0);
        @(posedge clk);
        #2 spur_ack = 1'b0;
        repeat (2) begin
          @(negedge clk);
          check("gap_spur_idle", mem_enable_o, 1'b0);
        end
      end
    join

    repeat (3) @(negedge clk);
    check("grant_q_drained", grant_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
